// File: rtl/cpu_defs.sv
// Shared types for the two-master memory arbiter: FSM states, owner encoding
// and the latched address-phase request.
package cpu_defs;

    localparam int unsigned MEM_ADDR_WIDTH = 32;
    localparam int unsigned MEM_LEN_WIDTH  = 8;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_ADDR,
        ARB_RDATA,
        ARB_WDATA,
        ARB_WRESP
    } mem_arb_state_t;

    typedef enum logic {
        ARB_OWNER_D,
        ARB_OWNER_I
    } mem_arb_owner_t;

    typedef struct packed {
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic [MEM_LEN_WIDTH-1:0]  len;
        logic                      we;
    } mem_req_t;

    function automatic mem_arb_owner_t other_owner(input mem_arb_owner_t owner);
        return (owner == ARB_OWNER_D) ? ARB_OWNER_I : ARB_OWNER_D;
    endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Combinational winner selection between icache and dcache requests.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-break; otherwise dcache wins ties.
module mem_arb_select
    import cpu_defs::*;
(
    input  logic           i_ireq,
    input  logic           i_dreq,
    input  mem_arb_owner_t i_last_owner,
    output mem_arb_owner_t o_winner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        o_winner = ARB_OWNER_D;
        if (i_ireq && i_dreq) begin
            o_winner = other_owner(i_last_owner);
        end else if (i_ireq) begin
            o_winner = ARB_OWNER_I;
        end
    end
`else
    // A data miss blocks the older instruction at MEM, so dcache always wins.
    logic w_unused_last_owner;
    assign w_unused_last_owner = i_last_owner;

    always_comb begin
        o_winner = ARB_OWNER_D;
        if (i_ireq && !i_dreq) begin
            o_winner = ARB_OWNER_I;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-master burst arbiter sharing the external memory port between icache and dcache.
// Build option MEM_ARB_ROUND_ROBIN_EN switches tie-break from dcache-priority to round-robin.
module mem_arbiter
    import cpu_defs::*;
#(
    parameter int unsigned BUS_WIDTH = 32,
    parameter int unsigned LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    // icache master
    input  logic                 i_req,
    input  logic [31:0]          i_addr,
    input  logic [LEN_WIDTH-1:0] i_len,
    output logic                 i_gnt,
    output logic                 i_rvalid,
    output logic [BUS_WIDTH-1:0] i_rdata,
    output logic                 i_rlast,
    // dcache master
    input  logic                 d_req,
    input  logic [31:0]          d_addr,
    input  logic [LEN_WIDTH-1:0] d_len,
    input  logic                 d_we,
    output logic                 d_gnt,
    output logic                 d_rvalid,
    output logic [BUS_WIDTH-1:0] d_rdata,
    output logic                 d_rlast,
    input  logic [BUS_WIDTH-1:0] d_wdata,
    output logic                 d_wready,
    output logic                 d_bvalid,
    // memory port
    output logic                 m_req,
    output logic [31:0]          m_addr,
    output logic [LEN_WIDTH-1:0] m_len,
    output logic                 m_we,
    input  logic                 m_ack,
    input  logic                 m_rvalid,
    input  logic [BUS_WIDTH-1:0] m_rdata,
    input  logic                 m_rlast,
    output logic                 m_wvalid,
    output logic [BUS_WIDTH-1:0] m_wdata,
    output logic                 m_wlast,
    input  logic                 m_wready,
    input  logic                 m_bvalid
);

    mem_arb_state_t       r_state;
    mem_arb_state_t       w_state_nxt;
    mem_arb_owner_t       r_owner;
    mem_arb_owner_t       r_rr_ptr;
    mem_arb_owner_t       w_winner;
    mem_arb_owner_t       w_last_owner;
    mem_req_t             r_req;
    logic [LEN_WIDTH-1:0] r_beat_cnt;
    logic                 w_start;
    logic                 w_wlast;
    logic                 w_done;

    // r_rr_ptr names the master favoured on the next tie (reset favours dcache).
    assign w_last_owner = other_owner(r_rr_ptr);
    assign w_start      = (r_state == ARB_IDLE) && (i_req || d_req);
    assign w_wlast      = (r_beat_cnt == LEN_WIDTH'(r_req.len));
    assign w_done       = ((r_state == ARB_RDATA) && m_rvalid && m_rlast) ||
                          ((r_state == ARB_WRESP) && m_bvalid);

    mem_arb_select u_select (
        .i_ireq       (i_req),
        .i_dreq       (d_req),
        .i_last_owner (w_last_owner),
        .o_winner     (w_winner)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Owner/request latch and write beat counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner    <= ARB_OWNER_D;
            r_req      <= '0;
            r_beat_cnt <= '0;
        end else if (w_start) begin
            r_owner    <= w_winner;
            r_beat_cnt <= '0;
            if (w_winner == ARB_OWNER_I) begin
                r_req.addr <= i_addr;
                r_req.len  <= MEM_LEN_WIDTH'(i_len);
                r_req.we   <= 1'b0;
            end else begin
                r_req.addr <= d_addr;
                r_req.len  <= MEM_LEN_WIDTH'(d_len);
                r_req.we   <= d_we;
            end
        end else if ((r_state == ARB_WDATA) && m_wready && !w_wlast) begin
            // Counter stops at len_q, so it can never wrap.
            r_beat_cnt <= r_beat_cnt + LEN_WIDTH'(1);
        end
    end

    // Round-robin pointer moves to the other master when a transaction completes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr <= ARB_OWNER_D;
        end else if (w_done) begin
            r_rr_ptr <= other_owner(r_owner);
        end
    end

    // Next-state and output decode
    always_comb begin
        w_state_nxt = r_state;
        m_req       = 1'b0;
        m_addr      = '0;
        m_len       = '0;
        m_we        = 1'b0;
        i_gnt       = 1'b0;
        d_gnt       = 1'b0;
        i_rvalid    = 1'b0;
        i_rdata     = '0;
        i_rlast     = 1'b0;
        d_rvalid    = 1'b0;
        d_rdata     = '0;
        d_rlast     = 1'b0;
        d_wready    = 1'b0;
        d_bvalid    = 1'b0;
        m_wvalid    = 1'b0;
        m_wdata     = '0;
        m_wlast     = 1'b0;

        case (r_state)
            ARB_IDLE: begin
                if (i_req || d_req) begin
                    w_state_nxt = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                m_req  = 1'b1;
                m_addr = r_req.addr;
                m_len  = LEN_WIDTH'(r_req.len);
                m_we   = r_req.we;
                if (m_ack) begin
                    i_gnt       = (r_owner == ARB_OWNER_I);
                    d_gnt       = (r_owner == ARB_OWNER_D);
                    w_state_nxt = r_req.we ? ARB_WDATA : ARB_RDATA;
                end
            end
            ARB_RDATA: begin
                if (r_owner == ARB_OWNER_I) begin
                    i_rvalid = m_rvalid;
                    i_rdata  = m_rdata;
                    i_rlast  = m_rlast;
                end else begin
                    d_rvalid = m_rvalid;
                    d_rdata  = m_rdata;
                    d_rlast  = m_rlast;
                end
                if (m_rvalid && m_rlast) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            ARB_WDATA: begin
                m_wvalid = 1'b1;
                m_wdata  = d_wdata;
                m_wlast  = w_wlast;
                d_wready = m_wready;
                if (m_wready && w_wlast) begin
                    w_state_nxt = ARB_WRESP;
                end
            end
            ARB_WRESP: begin
                if (m_bvalid) begin
                    d_bvalid    = 1'b1;
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a cycle-driven memory model feeds a
// scoreboard of expected read/write beats that is popped as the DUT forwards them.
module tb_mem_arbiter;
    import cpu_defs::*;

    localparam int unsigned BW   = 32;
    localparam int unsigned LW   = 8;
    localparam int unsigned OUTW = 44 + LW + 3 * BW;

    logic          clk, rst;
    logic          i_req, i_gnt, i_rvalid, i_rlast;
    logic [31:0]   i_addr;
    logic [LW-1:0] i_len;
    logic [BW-1:0] i_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid, d_rlast, d_wready, d_bvalid;
    logic [31:0]   d_addr;
    logic [LW-1:0] d_len;
    logic [BW-1:0] d_rdata, d_wdata;
    logic          m_req, m_we, m_ack, m_rvalid, m_rlast, m_wvalid, m_wlast, m_wready, m_bvalid;
    logic [31:0]   m_addr;
    logic [LW-1:0] m_len;
    logic [BW-1:0] m_rdata, m_wdata;
    logic [OUTW-1:0] all_out;

    typedef struct {
        logic [BW-1:0] data;
        logic          last;
    } beat_t;

    beat_t sb_q[$];
    int    checks   = 0;
    int    failures = 0;

    mem_arbiter #(.BUS_WIDTH(BW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_len(i_len), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rlast(i_rlast),
        .d_req(d_req), .d_addr(d_addr), .d_len(d_len), .d_we(d_we), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rlast(d_rlast),
        .d_wdata(d_wdata), .d_wready(d_wready), .d_bvalid(d_bvalid),
        .m_req(m_req), .m_addr(m_addr), .m_len(m_len), .m_we(m_we), .m_ack(m_ack),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rlast(m_rlast),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wlast(m_wlast),
        .m_wready(m_wready), .m_bvalid(m_bvalid)
    );

    assign all_out = {m_req, m_wvalid, i_gnt, d_gnt, i_rvalid, d_rvalid, i_rlast, d_rlast,
                      d_wready, d_bvalid, m_we, m_wlast, m_addr, m_len, m_wdata, i_rdata, d_rdata};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs();
        i_req = 0; i_addr = '0; i_len = '0;
        d_req = 0; d_addr = '0; d_len = '0; d_we = 0; d_wdata = '0;
        m_ack = 0; m_rvalid = 0; m_rdata = '0; m_rlast = 0;
        m_wready = 0; m_bvalid = 0;
    endtask

    // Serves one transaction from its IDLE cycle; the caller has just driven the request(s).
    task automatic mem_xact(input bit exp_i, input logic [31:0] exp_addr, input logic [LW-1:0] len,
                            input bit we, input logic [3:0] stall_mask, input int ack_delay,
                            input bit drop_req);
        beat_t         exp_b;
        logic [BW-1:0] got_data;
        logic          got_last;
        int            beat, dw_pulses;
        bit            stall, stalled;

        @(negedge clk);
        checks++;
        if (m_req !== 1'b0) begin
            failures++; $display("FAIL idle_bubble m_req=%b exp=0", m_req);
        end
        next_cyc();
        for (int k = 0; k < ack_delay; k++) begin
            @(negedge clk);
            checks++;
            if ({m_req, i_gnt, d_gnt} !== 3'b100) begin
                failures++; $display("FAIL gnt_before_ack req/ig/dg=%b exp=100", {m_req, i_gnt, d_gnt});
            end
            next_cyc();
        end
        m_ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({m_req, m_addr, m_len, m_we} !== {1'b1, exp_addr, len, we}) begin
            failures++;
            $display("FAIL addr_phase req=%b addr=%h len=%0d we=%b exp addr=%h len=%0d we=%b",
                     m_req, m_addr, m_len, m_we, exp_addr, len, we);
        end
        checks++;
        if ({i_gnt, d_gnt} !== {exp_i, !exp_i}) begin
            failures++; $display("FAIL grant ig/dg=%b%b exp=%b%b", i_gnt, d_gnt, exp_i, !exp_i);
        end
        next_cyc();
        m_ack = 1'b0;
        if (drop_req) begin
            if (exp_i) i_req = 1'b0;
            else       d_req = 1'b0;
        end

        if (!we) begin
            for (int b = 0; b <= int'(len); b++) begin
                if (b == 1) begin
                    m_rvalid = 1'b0; m_rdata = $urandom; m_rlast = 1'b1;
                    @(negedge clk);
                    checks++;
                    if ({i_rvalid, d_rvalid} !== 2'b00) begin
                        failures++; $display("FAIL rgap irv/drv=%b exp=00", {i_rvalid, d_rvalid});
                    end
                    next_cyc();
                end
                m_rvalid = 1'b1; m_rdata = $urandom; m_rlast = (b == int'(len));
                sb_q.push_back('{data: m_rdata, last: m_rlast});
                @(negedge clk);
                checks++;
                if ((exp_i ? d_rvalid : i_rvalid) !== 1'b0) begin
                    failures++; $display("FAIL rbeat_nonowner beat=%0d rvalid=1 exp=0", b);
                end
                checks++;
                if ((exp_i ? i_rvalid : d_rvalid) !== 1'b1) begin
                    failures++; $display("FAIL rbeat_valid beat=%0d rvalid=0 exp=1", b);
                end else begin
                    exp_b    = sb_q.pop_front();
                    got_data = exp_i ? i_rdata : d_rdata;
                    got_last = exp_i ? i_rlast : d_rlast;
                    checks++;
                    if ({got_data, got_last} !== {exp_b.data, exp_b.last}) begin
                        failures++;
                        $display("FAIL rbeat_data beat=%0d data=%h last=%b exp data=%h last=%b",
                                 b, got_data, got_last, exp_b.data, exp_b.last);
                    end
                end
                next_cyc();
            end
            m_rvalid = 1'b0; m_rlast = 1'b0;
        end else begin
            beat = 0; dw_pulses = 0; stalled = 0;
            d_wdata = $urandom;
            sb_q.push_back('{data: d_wdata, last: (len == '0)});
            for (int c = 0; (beat <= int'(len)) && (c < 64); c++) begin
                stall    = (beat < 4) && stall_mask[2'(beat)] && !stalled;
                m_wready = !stall;
                @(negedge clk);
                checks++;
                if ({m_wvalid, m_wdata, m_wlast} !== {1'b1, sb_q[0].data, sb_q[0].last}) begin
                    failures++;
                    $display("FAIL wbeat beat=%0d wvalid=%b data=%h wlast=%b exp 1 %h %b",
                             beat, m_wvalid, m_wdata, m_wlast, sb_q[0].data, sb_q[0].last);
                end
                checks++;
                if (d_wready !== m_wready || dut.r_beat_cnt > len) begin
                    failures++;
                    $display("FAIL wready beat=%0d d_wready=%b cnt=%0d exp wready=%b cnt<=%0d",
                             beat, d_wready, dut.r_beat_cnt, m_wready, len);
                end
                if (d_wready === 1'b1) dw_pulses++;
                next_cyc();
                if (stall) begin
                    stalled = 1;
                end else begin
                    void'(sb_q.pop_front());
                    beat++;
                    stalled = 0;
                    if (beat <= int'(len)) begin
                        d_wdata = $urandom;
                        sb_q.push_back('{data: d_wdata, last: (beat == int'(len))});
                    end
                end
            end
            m_wready = 1'b0;
            checks++;
            if (dw_pulses != int'(len) + 1) begin
                failures++; $display("FAIL wready_pulses got=%0d exp=%0d", dw_pulses, int'(len) + 1);
            end
            @(negedge clk);
            checks++;
            if ({m_wvalid, d_wready, d_bvalid} !== 3'b000) begin
                failures++; $display("FAIL wresp_wait wv/wr/bv=%b exp=000", {m_wvalid, d_wready, d_bvalid});
            end
            next_cyc();
            m_bvalid = 1'b1;
            @(negedge clk);
            checks++;
            if (d_bvalid !== 1'b1) begin
                failures++; $display("FAIL bvalid got=%b exp=1", d_bvalid);
            end
            next_cyc();
            m_bvalid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        init_inputs();
        @(negedge clk);
        checks++;
        if (all_out !== '0 || dut.r_state !== ARB_IDLE) begin
            failures++; $display("FAIL reset_outputs out=%h exp=0", all_out);
        end
        next_cyc();
        next_cyc();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (all_out !== '0) begin
            failures++; $display("FAIL reset_release out=%h exp=0", all_out);
        end
        next_cyc();
    endtask

    task automatic test_icache_read();
        i_req = 1'b1; i_addr = 32'h1FC0_0000; i_len = 8'd7;
        mem_xact(1'b1, 32'h1FC0_0000, 8'd7, 1'b0, 4'b0000, 2, 1'b1);
        checks++;
        if (sb_q.size() != 0) begin
            failures++; $display("FAIL icache_sb_left got=%0d exp=0", sb_q.size());
        end
    endtask

    task automatic test_dcache_write();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8000_0100; d_len = 8'd3;
        mem_xact(1'b0, 32'h8000_0100, 8'd3, 1'b1, 4'b0110, 0, 1'b1);
    endtask

    task automatic test_single_write();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8000_0200; d_len = 8'd0;
        mem_xact(1'b0, 32'h8000_0200, 8'd0, 1'b1, 4'b0000, 1, 1'b1);
        sb_q.delete();
    endtask

    task automatic test_arbitration();
        bit fav_i = 1'b0;
        bit exp_i;
        d_we = 1'b0;
        i_addr = 32'h0000_4000; i_len = 8'd1;
        d_addr = 32'h0001_8000; d_len = 8'd2;
        i_req = 1'b1; d_req = 1'b1;
        for (int t = 0; t < 4; t++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_i = fav_i;
            fav_i = !fav_i;
`else
            exp_i = fav_i;
`endif
            mem_xact(exp_i, exp_i ? 32'h0000_4000 : 32'h0001_8000,
                     exp_i ? 8'd1 : 8'd2, 1'b0, 4'b0000, 0, 1'b0);
        end
        d_req = 1'b0;
        mem_xact(1'b1, 32'h0000_4000, 8'd1, 1'b0, 4'b0000, 0, 1'b1);
        checks++;
        if (sb_q.size() != 0) begin
            failures++; $display("FAIL arb_sb_left got=%0d exp=0", sb_q.size());
        end
    endtask

    task automatic test_stray_responses();
        m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 32'hDEAD_BEEF; m_bvalid = 1'b1; m_wready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (all_out !== '0 || dut.r_state !== ARB_IDLE) begin
                failures++; $display("FAIL stray_resp out=%h exp=0", all_out);
            end
            next_cyc();
        end
        m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0; m_bvalid = 1'b0; m_wready = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        beat_t exp_b;
        i_req = 1'b1; i_addr = 32'h1FC0_0040; i_len = 8'd7;
        next_cyc();
        m_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (i_gnt !== 1'b1) begin
            failures++; $display("FAIL rmb_grant got=%b exp=1", i_gnt);
        end
        next_cyc();
        m_ack = 1'b0; i_req = 1'b0;
        for (int b = 0; b < 4; b++) begin
            m_rvalid = 1'b1; m_rdata = $urandom; m_rlast = 1'b0;
            sb_q.push_back('{data: m_rdata, last: 1'b0});
            if (b < 3) begin
                @(negedge clk);
                exp_b = sb_q.pop_front();
                checks++;
                if ({i_rvalid, i_rdata} !== {1'b1, exp_b.data}) begin
                    failures++;
                    $display("FAIL rmb_beat beat=%0d rv=%b data=%h exp 1 %h", b, i_rvalid, i_rdata, exp_b.data);
                end
                next_cyc();
            end
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
            failures++; $display("FAIL rmb_async_reset out=%h exp=0", all_out);
        end
        sb_q.delete();
        next_cyc();
        m_rvalid = 1'b0; m_rdata = '0;
        next_cyc();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (dut.r_state !== ARB_IDLE || all_out !== '0) begin
            failures++; $display("FAIL rmb_idle_after state=%0d out=%h exp IDLE 0", dut.r_state, all_out);
        end
        next_cyc();
        i_req = 1'b1; i_addr = 32'h1FC0_0080; i_len = 8'd3;
        mem_xact(1'b1, 32'h1FC0_0080, 8'd3, 1'b0, 4'b0000, 0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_icache_read();
        test_dcache_write();
        test_single_write();
        test_arbitration();
        test_stray_responses();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
